// File: rtl/audio_pkg.sv
// Shared audio constants and types for the codec data path.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned SLOT_W   = 32;

  typedef logic [15:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_sample_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with a history flop; single-cycle rise/fall pulses in the clk domain.
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_hist <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_hist;
  assign o_fall = ~r_sync & r_hist;

endmodule

// File: rtl/i2s_dac_serializer.sv
// I2S DAC serializer: buffers one stereo pair and shifts it MSB-first onto AUD_DACDAT,
// following codec-mastered BCLK/LRCK; counts left frames that start with no pair buffered.
module i2s_dac_serializer #(
  parameter int unsigned SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int unsigned SLOT_W   = audio_pkg::SLOT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] left_data,
  input  logic [SAMPLE_W-1:0] right_data,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                AUD_BCLK,
  input  logic                AUD_DACLRCK,
  output logic                AUD_DACDAT,
  output logic                underrun,
  output logic [15:0]         underrun_count
);

  localparam int unsigned CNT_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   DATA_BITS = (CNT_W+1)'(SAMPLE_W);

  logic w_bclk_fall;
  logic w_unused_bclk_rise;
  logic w_lrck_rise;
  logic w_lrck_fall;
  logic w_accept;

  logic                r_run;
  logic                r_buf_full;
  logic [SAMPLE_W-1:0] r_buf_left;
  logic [SAMPLE_W-1:0] r_buf_right;
  logic [SAMPLE_W-1:0] r_shift;
  logic [SAMPLE_W-1:0] r_right_hold;
  logic                r_pair_loaded;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic                r_dacdat;
  logic                r_underrun;
  logic [15:0]         r_underrun_count;

  sync_edge_detect u_bclk_sync (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_async (AUD_BCLK),
    .o_rise  (w_unused_bclk_rise),
    .o_fall  (w_bclk_fall)
  );

  sync_edge_detect u_lrck_sync (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_async (AUD_DACLRCK),
    .o_rise  (w_lrck_rise),
    .o_fall  (w_lrck_fall)
  );

  // r_run keeps ready low while reset is held even though buf_full is already clear.
  assign sample_ready = enable & ~r_buf_full & r_run;
  assign w_accept     = sample_valid & sample_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run            <= 1'b0;
      r_buf_full       <= 1'b0;
      r_buf_left       <= '0;
      r_buf_right      <= '0;
      r_shift          <= '0;
      r_right_hold     <= '0;
      r_pair_loaded    <= 1'b0;
      r_bit_cnt        <= '0;
      r_dacdat         <= 1'b0;
      r_underrun       <= 1'b0;
      r_underrun_count <= '0;
    end else begin
      r_run      <= 1'b1;
      r_underrun <= 1'b0;

      if (w_accept) begin
        r_buf_left  <= left_data;
        r_buf_right <= right_data;
        r_buf_full  <= 1'b1;
      end

      // LRCK edges outrank a coincident BCLK fall: that fall is the I2S one-bit delay.
      if (w_lrck_fall) begin
        r_bit_cnt <= '0;
        if (r_buf_full && enable) begin
          r_shift       <= r_buf_left;
          r_right_hold  <= r_buf_right;
          r_pair_loaded <= 1'b1;
          r_buf_full    <= 1'b0;
        end else begin
          r_shift       <= '0;
          r_pair_loaded <= 1'b0;
          if (enable) begin
            r_underrun       <= 1'b1;
            r_underrun_count <= audio_pkg::sat_inc16(r_underrun_count);
          end
        end
      end else if (w_lrck_rise) begin
        r_bit_cnt <= '0;
        r_shift   <= r_pair_loaded ? r_right_hold : '0;
      end else if (w_bclk_fall) begin
        if (r_bit_cnt != CNT_MAX) begin
          r_bit_cnt <= r_bit_cnt + CNT_ONE;
        end
        if ({1'b0, r_bit_cnt} < DATA_BITS) begin
          r_dacdat <= r_shift[SAMPLE_W-1];
          r_shift  <= {r_shift[SAMPLE_W-2:0], 1'b0};
        end else begin
          r_dacdat <= 1'b0;
        end
      end
    end
  end

  assign AUD_DACDAT     = r_dacdat;
  assign underrun       = r_underrun;
  assign underrun_count = r_underrun_count;

endmodule
